// File: rtl/run_seq_pkg.sv
// Shared types for the run sequencer: FSM state encoding and byte type.
package run_seq_pkg;

  localparam int AW_DEF = 8;

  typedef logic [7:0] byte_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_RUN   = 3'd3,
    S_DRAIN = 3'd4
  } state_e;

endpackage

// File: rtl/run_watchdog.sv
// RUN-cycle watchdog. The counter reads 1 on the first enabled cycle and
// expired is raised on the cycle it reaches TIMEOUT.
module run_watchdog #(
  parameter int TIMEOUT = 4096
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: reload to 1 while cleared so the first RUN cycle counts as 1;
  // saturate at TIMEOUT.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)
      cnt_d = CW'(1);
    else if (en_i && (cnt_q != CW'(TIMEOUT)))
      cnt_d = cnt_q + CW'(1);
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expired_o = en_i && (cnt_q == CW'(TIMEOUT));

endmodule

// File: rtl/run_sequencer.sv
// Host-side sequencer: preloads core data memory from a byte stream, kicks the
// core, supervises the run with a watchdog, then streams out a result window.
module run_sequencer
  import run_seq_pkg::*;
#(
  parameter int          AW       = AW_DEF,
  parameter logic [AW-1:0] RES_BASE = AW'(64),
  parameter int          RES_LEN  = 16,
  parameter int          TIMEOUT  = 4096
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW:0]   load_len,
  input  logic [AW-1:0] load_base,
  input  logic          in_valid,
  output logic          in_ready,
  input  byte_t         in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output byte_t         out_data,
  output logic          busy,
  output logic          timeout_err,
  output logic          proc_reset,
  output logic          proc_req,
  input  logic          proc_done,
  output logic          mem_sel,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output byte_t         mem_wdata,
  input  byte_t         mem_rdata
);

  state_e        state_q, state_d;
  logic [AW:0]   len_q;
  logic [AW-1:0] base_q;
  logic [AW:0]   cnt_q;
  logic [AW:0]   idx_q;
  logic          terr_q;

  logic start_acc, load_beat, last_load, drain_beat, last_drain;
  logic wd_expired, run_abort;

  assign start_acc  = (state_q == S_IDLE) && start;
  assign load_beat  = (state_q == S_LOAD) && in_valid;
  assign last_load  = (cnt_q + (AW+1)'(1)) == len_q;
  assign drain_beat = (state_q == S_DRAIN) && out_ready;
  assign last_drain = idx_q == (AW+1)'(RES_LEN - 1);
  // A done seen on the expiry cycle takes priority over the abort.
  assign run_abort  = (state_q == S_RUN) && wd_expired && !proc_done;

  run_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (state_q != S_RUN),
    .en_i      (state_q == S_RUN),
    .expired_o (wd_expired)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = (load_len != '0) ? S_LOAD : S_START;
      S_LOAD:  if (load_beat && last_load) state_d = S_START;
      S_START: state_d = S_RUN;
      S_RUN:   if (proc_done || wd_expired) state_d = S_DRAIN;
      S_DRAIN: if (drain_beat && last_drain) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Job capture, load counter, drain index and sticky timeout flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_q  <= '0;
      base_q <= '0;
      cnt_q  <= '0;
      idx_q  <= '0;
      terr_q <= 1'b0;
    end else if (start_acc) begin
      len_q  <= load_len;
      base_q <= load_base;
      cnt_q  <= '0;
      idx_q  <= '0;
      terr_q <= 1'b0;
    end else begin
      if (load_beat)  cnt_q  <= cnt_q + (AW+1)'(1);
      if (drain_beat) idx_q  <= idx_q + (AW+1)'(1);
      if (run_abort)  terr_q <= 1'b1;
    end
  end

  // Output decode from registered state; write enable and read data pass through.
  always_comb begin
    busy       = (state_q != S_IDLE);
    proc_reset = 1'b1;
    proc_req   = 1'b0;
    mem_sel    = 1'b1;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    mem_wr_en  = 1'b0;
    mem_addr   = '0;
    case (state_q)
      S_LOAD: begin
        in_ready  = 1'b1;
        mem_wr_en = in_valid;
        mem_addr  = base_q + cnt_q[AW-1:0];
      end
      S_START: begin
        proc_reset = 1'b0;
        proc_req   = 1'b1;
        mem_sel    = 1'b0;
      end
      S_RUN: begin
        proc_reset = 1'b0;
        mem_sel    = 1'b0;
      end
      S_DRAIN: begin
        out_valid = 1'b1;
        mem_addr  = RES_BASE + idx_q[AW-1:0];
      end
      default: ;
    endcase
  end

  assign mem_wdata   = in_data;
  assign out_data    = mem_rdata;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_run_sequencer.sv
// Directed bench for run_sequencer with a behavioural data memory.
module tb_run_sequencer;
  import run_seq_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [8:0] load_len = '0;
  logic [7:0] load_base = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  byte_t      in_data = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  byte_t      out_data;
  logic       busy, timeout_err, proc_reset, proc_req;
  logic       proc_done = 1'b0;
  logic       mem_sel, mem_wr_en;
  logic [7:0] mem_addr;
  byte_t      mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  run_sequencer #(.AW(8), .RES_BASE(8'd64), .RES_LEN(16), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .start(start), .load_len(load_len), .load_base(load_base),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .timeout_err(timeout_err), .proc_reset(proc_reset), .proc_req(proc_req),
    .proc_done(proc_done), .mem_sel(mem_sel), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  byte_t mem [256];
  always @(posedge clk) if (mem_sel && mem_wr_en) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [7:0]       base;
    logic [8:0]       len;
    logic [0:3][7:0]  dat;
    logic [0:3][7:0]  addr;
    int               done_k;
    bit               stall;
  } load_vec_t;

  load_vec_t vec [3];

  task automatic do_start(input logic [7:0] b, input logic [8:0] l);
    @(negedge clk);
    start = 1'b1; load_base = b; load_len = l;
    #1 chk("idle_busy", busy, 0);
    @(negedge clk);
    start = 1'b0;
    #1 chk("busy_after_start", busy, 1);
  endtask

  task automatic check_start();
    #1;
    chk("start_req", proc_req, 1);
    chk("start_preset", proc_reset, 0);
    chk("start_memsel", mem_sel, 0);
    chk("start_inready", in_ready, 0);
  endtask

  // RUN for k cycles; done raised on cycle k if give_done, else watchdog ends it.
  task automatic run_cycles(input int k, input bit give_done, input bit exp_err);
    @(negedge clk);
    for (int c = 1; c <= k; c++) begin
      proc_done = give_done && (c == k);
      start     = (c == 2);  // must be ignored outside IDLE
      #1;
      chk("run_memsel", mem_sel, 0);
      chk("run_req", proc_req, 0);
      chk("run_wren", mem_wr_en, 0);
      @(negedge clk);
    end
    proc_done = 1'b0;
    start     = 1'b0;
    #1;
    chk("drain_entry_valid", out_valid, 1);
    chk("drain_preset", proc_reset, 1);
    chk("drain_terr", timeout_err, exp_err);
  endtask

  task automatic drain(input bit stall);
    int idx = 0;
    int guard = 0;
    while (idx < 16 && guard < 100) begin
      out_ready = stall ? guard[0] : 1'b1;
      #1;
      chk("drain_valid", out_valid, 1);
      chk("drain_data", out_data, idx);
      chk("drain_addr", mem_addr, 64 + idx);
      if (out_ready) idx++;
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) chk("drain_bound", idx, 16);
    out_ready = 1'b0;
    #1;
    chk("end_busy", busy, 0);
    chk("end_valid", out_valid, 0);
    chk("end_memsel", mem_sel, 1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'hEE;
    for (int i = 0; i < 16; i++) mem[64 + i] = 8'(i);

    vec[0].base = 8'h05; vec[0].len = 9'd3; vec[0].dat = {8'h11, 8'h22, 8'h33, 8'h00};
    vec[0].addr = {8'h05, 8'h06, 8'h07, 8'h00}; vec[0].done_k = 10; vec[0].stall = 1'b1;
    vec[1].base = 8'hFE; vec[1].len = 9'd4; vec[1].dat = {8'hA1, 8'hB2, 8'hC3, 8'hD4};
    vec[1].addr = {8'hFE, 8'hFF, 8'h00, 8'h01}; vec[1].done_k = 3; vec[1].stall = 1'b0;
    vec[2].base = 8'h80; vec[2].len = 9'd1; vec[2].dat = {8'h5A, 8'h00, 8'h00, 8'h00};
    vec[2].addr = {8'h80, 8'h00, 8'h00, 8'h00}; vec[2].done_k = 1; vec[2].stall = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_preset", proc_reset, 1);
    chk("rst_busy", busy, 0);
    chk("rst_inready", in_ready, 0);
    chk("rst_outvalid", out_valid, 0);
    chk("rst_memsel", mem_sel, 1);
    chk("rst_terr", timeout_err, 0);
    chk("rst_req", proc_req, 0);
    @(negedge clk);
    reset = 1'b1;

    // Stream bytes outside LOAD are not accepted
    in_valid = 1'b1; in_data = 8'h99;
    #1;
    chk("idle_wren", mem_wr_en, 0);
    chk("idle_inready", in_ready, 0);
    in_valid = 1'b0;

    // Table-driven load/run/drain jobs
    for (int v = 0; v < 3; v++) begin
      do_start(vec[v].base, vec[v].len);
      for (int i = 0; i < int'(vec[v].len); i++) begin
        in_valid = 1'b1; in_data = vec[v].dat[i];
        #1;
        chk("load_ready", in_ready, 1);
        chk("load_wren", mem_wr_en, 1);
        chk("load_addr", mem_addr, vec[v].addr[i]);
        chk("load_wdata", mem_wdata, vec[v].dat[i]);
        @(negedge clk);
      end
      in_valid = 1'b0;
      check_start();
      for (int i = 0; i < int'(vec[v].len); i++)
        chk("mem_content", mem[vec[v].addr[i]], vec[v].dat[i]);
      run_cycles(vec[v].done_k, 1'b1, 1'b0);
      drain(vec[v].stall);
    end

    // Reset mid-LOAD after two beats
    do_start(8'h20, 9'd5);
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h70 + i);
      @(negedge clk);
    end
    reset = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_inready", in_ready, 0);
    chk("midrst_wren", mem_wr_en, 0);
    chk("midrst_preset", proc_reset, 1);
    chk("midrst_mem0", mem[8'h20], 8'h70);
    chk("midrst_mem1", mem[8'h21], 8'h71);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // Zero-length job straight to START; watchdog abort
    do_start(8'h00, 9'd0);
    check_start();
    run_cycles(16, 1'b0, 1'b1);
    drain(1'b0);
    chk("terr_sticky_idle", timeout_err, 1);

    // Next start clears the error; done on the expiry cycle wins
    do_start(8'h00, 9'd0);
    chk("terr_cleared", timeout_err, 0);
    check_start();
    run_cycles(16, 1'b1, 1'b0);
    drain(1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/run_sequencer.md
# run_sequencer

Host-side sequencer sitting directly upstream of the 9-bit processor core. It preloads operands into the core's data memory from a byte stream, holds the core in reset while loading, pulses `req`, supervises the run until `done` (or a watchdog timeout), then streams a result window out of data memory. It owns the data-memory port whenever the core is not running.

## Interface
Parameters:
- AW, 8, data-memory address width (256 bytes)
- RES_BASE, 8'd64, first data-memory address of the result window
- RES_LEN, 16, number of result bytes drained (1..2**AW)
- TIMEOUT, 4096, maximum RUN cycles before abort (≥2)

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low; all state cleared immediately on assertion
- start  in  1  single-cycle request to begin a job; honoured only in IDLE
- load_len  in  AW+1  bytes to preload (0..256), captured when start is accepted
- load_base  in  AW  first preload address, captured when start is accepted
- in_valid / in_ready / in_data  in/out/in  1/1/8  preload byte stream
- out_valid / out_ready / out_data  out/in/out  1/1/8  result byte stream
- busy  out  1  high in every state except IDLE
- timeout_err  out  1  sticky per job: set on watchdog abort, cleared at next accepted start
- proc_reset  out  1  active-high reset to the core
- proc_req  out  1  one-cycle start pulse to the core
- proc_done  in  1  core completion flag
- mem_sel  out  1  1 = this block drives the data-memory port
- mem_wr_en / mem_addr / mem_wdata  out  1/AW/8  data-memory write port
- mem_rdata  in  8  data-memory combinational read data at mem_addr

## Operation
- States: IDLE, LOAD, START, RUN, DRAIN.
- IDLE: proc_reset=1, mem_sel=1, in_ready=0, out_valid=0. On start: capture load_len/load_base, clear timeout_err, clear counters; go LOAD if load_len≠0, else START.
- LOAD: in_ready=1. Each beat with in_valid&in_ready: mem_wr_en=1 same cycle, mem_addr=load_base+cnt (mod 2**AW, wraps), mem_wdata=in_data; cnt++. Beat that makes cnt==load_len → START.
- START: exactly one cycle; proc_reset=0, proc_req=1, mem_sel=0. proc_done ignored here. → RUN.
- RUN: proc_reset=0, mem_sel=0, mem_wr_en=0. Watchdog counts from 1. proc_done=1 → DRAIN. Watchdog reaching TIMEOUT with no done → set timeout_err, → DRAIN. proc_done on the TIMEOUT cycle wins (no error).
- DRAIN: proc_reset=1, mem_sel=1, mem_addr=RES_BASE+idx (wraps), out_data=mem_rdata, out_valid=1. Address held while out_valid&!out_ready. On handshake idx++; final beat (idx==RES_LEN-1) → IDLE.
- start outside IDLE ignored; in_valid outside LOAD not accepted.

## Timing
- Reset values: state IDLE, busy=0, timeout_err=0, proc_reset=1, proc_req=0, mem_sel=1, mem_wr_en=0, in_ready=0, out_valid=0, counters 0.
- start at cycle 0 → LOAD (or START) at cycle 1; busy=1 from cycle 1.
- Full-rate load: N bytes take N cycles; START one cycle after last beat; proc_req visible one cycle, RUN next.
- proc_done sampled at cycle k of RUN → DRAIN at k+1, first out_valid at k+1.
- Full-rate drain: RES_LEN cycles; IDLE the cycle after last handshake; new start accepted that cycle.
- All control outputs are decoded from registered state; mem_wr_en, out_data combinational from handshake/mem_rdata.
- Reset asserted mid-job: immediate return to IDLE values; partial memory contents are not undone.

## Structure
- Package run_seq_pkg: state enum (IDLE, LOAD, START, RUN, DRAIN), AW default, byte typedef.
- One sub-module: run_watchdog (clear/enable inputs, expired output) holding the RUN cycle counter up to TIMEOUT.
- Top holds FSM, load counter, drain index, address mux.

## Test plan
- Reset check: hold reset=0 → proc_reset=1, busy=0, in_ready=0, out_valid=0, mem_sel=1.
- Load 3 bytes 0x11,0x22,0x33 at load_base=0x05, full rate → writes to 0x05,0x06,0x07 in 3 consecutive cycles, proc_req single pulse next cycle.
- load_base=0xFE, load_len=4 → writes 0xFE,0xFF,0x00,0x01 (wrap).
- proc_done after 10 RUN cycles, memory 64..79 = 0x00..0x0F, out_ready toggled every other cycle → 16 beats 0x00..0x0F in order, data stable under stall, timeout_err=0.
- proc_done never asserted, TIMEOUT=16 → DRAIN entered after 16 RUN cycles, timeout_err=1, cleared by next start.
- Reset pulsed mid-LOAD after 2 beats → immediate IDLE; subsequent job with load_len=0 goes IDLE→START→RUN directly.
